// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: access-size and owner encodings shared by the memory arbiter
package mem_arbiter_pkg;
   localparam logic [1:0] MemByte = 2'b00;
   localparam logic [1:0] MemHalf = 2'b01;
   localparam logic [1:0] MemWord = 2'b10;
   localparam logic OwnMem = 1'b0;
   localparam logic OwnIf  = 1'b1;
   function automatic logic [2:0] size_bytes(input logic [1:0] s);
      return (s == MemByte) ? 3'd1 : (s == MemHalf) ? 3'd2 : (s == MemWord) ? 3'd4 : 3'd1;
   endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates IF/MEM onto a byte-wide RAM, serializing accesses little-endian
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_data,
   output logic              if_done,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_done,
   output logic              busy,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr
);
   typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;
   state_t            r_state;
   logic [2:0]        r_cnt;
   logic [2:0]        r_n;
   logic              r_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_last_a;
   logic [31:0]       r_wdata;
   logic [31:0]       r_buf;
   logic              w_acc;
   logic              w_fin;
   logic [ADDR_W-1:0] w_a;
   logic [1:0]        w_idx;
   assign w_acc = r_state == ACCESS;
   assign w_fin = r_state == FINISH && rdy;
   assign w_a   = r_addr + ADDR_W'(r_cnt);
   assign w_idx = r_cnt[1:0] - 2'd1;
   assign ram_a     = w_acc ? w_a : r_last_a;
   assign ram_wr    = w_acc && r_we && rdy;
   assign ram_dout  = (w_acc && r_we) ? r_wdata[8*r_cnt[1:0] +: 8] : 8'd0;
   assign if_done   = w_fin && r_owner == OwnIf;
   assign mem_done  = w_fin && r_owner == OwnMem;
   assign if_data   = r_buf;
   assign mem_rdata = r_buf;
   assign busy      = r_state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= 3'd0;
         r_n      <= 3'd0;
         r_owner  <= OwnMem;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_last_a <= '0;
         r_wdata  <= 32'd0;
         r_buf    <= 32'd0;
      end else if (rdy) begin
         case (r_state)
            IDLE: if (mem_req || if_req) begin
               r_owner <= mem_req ? OwnMem : OwnIf;
               r_we    <= mem_req && mem_we;
               r_n     <= mem_req ? size_bytes(mem_size) : 3'd4;
               r_addr  <= mem_req ? mem_addr : if_addr;
               r_wdata <= mem_wdata;
               r_buf   <= 32'd0;
               r_cnt   <= 3'd0;
               r_state <= ACCESS;
            end
            ACCESS: begin
               r_last_a <= w_a;
               r_cnt    <= r_cnt + 3'd1;
               if (!r_we && r_cnt != 3'd0) r_buf[8*w_idx +: 8] <= ram_din;
               if (r_cnt == (r_we ? r_n - 3'd1 : r_n)) r_state <= FINISH;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table, corner-case and random checks of mem_arbiter against a transaction model
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic [31:0] if_data;
   logic        if_done;
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [1:0]  mem_size = 2'd0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        busy;
   logic [7:0]  ram_din = 8'd0;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic [7:0]  ram_arr [0:65535];
   logic [7:0]  ref_mem [0:65535];
   int n_cmp = 0;
   int n_bad = 0;

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rdy) begin
         if (ram_wr) ram_arr[ram_a[15:0]] <= ram_dout;
         ram_din <= ram_arr[ram_a[15:0]];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
      logic [31:0] r = 32'd0;
      logic [31:0] p;
      for (int i = 0; i < n; i++) begin
         p = a + 32'(i);
         r |= 32'(ref_mem[p[15:0]]) << (8 * i);
      end
      return r;
   endfunction

   task automatic run(input logic is_if, input logic we, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int st_at, input int st_len, output logic [31:0] got);
      int n, c, ec, lat;
      logic done, odone, pr;
      logic [31:0] p;
      n = is_if ? 4 : (sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4);
      lat = ((we && !is_if) ? n + 1 : n + 2) + (st_at > 0 ? st_len : 0);
      @(negedge clk);
      if_req = is_if; if_addr = a;
      mem_req = !is_if; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd;
      c = 0; ec = 0; done = 1'b0;
      while (!done && c < 40) begin
         pr = rdy;
         @(negedge clk);
         c++;
         if (pr) ec++;
         done  = is_if ? if_done : mem_done;
         odone = is_if ? mem_done : if_done;
         chk("ram_wr", {31'd0, ram_wr}, {31'd0, rdy && we && !is_if && ec >= 1 && ec <= n});
         if (ec >= 1 && ec <= n) begin
            chk("ram_a", ram_a, a + 32'(ec - 1));
            if (we && !is_if) chk("ram_dout", {24'd0, ram_dout}, (wd >> (8 * (ec - 1))) & 32'hFF);
         end
         chk("other_done", {31'd0, odone}, 32'd0);
         chk("busy", {31'd0, busy}, 32'd1);
         if (st_at > 0 && c == st_at) rdy = 1'b0;
         if (st_at > 0 && c == st_at + st_len) rdy = 1'b1;
      end
      chk("done_cycle", 32'(c), 32'(lat));
      got = is_if ? if_data : mem_rdata;
      if_req = 1'b0; mem_req = 1'b0; rdy = 1'b1;
      if (we && !is_if) begin
         chk("wr_rdata_zero", got, 32'd0);
         for (int i = 0; i < n; i++) begin
            p = a + 32'(i);
            ref_mem[p[15:0]] = wd[8*i +: 8];
         end
      end
   endtask

   typedef struct {
      logic        is_if;
      logic        we;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp;
      int          st;
   } vec_t;

   vec_t tbl [13];

   initial begin
      logic [31:0] got, a, wd;
      logic [1:0]  sz;
      logic        is_if, we;
      int c, n, st, bad_done;
      tbl[0]  = '{1'b0, 1'b1, 2'd2, 32'h0000_1000, 32'h4433_2211, 32'h0,         0};
      tbl[1]  = '{1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0,         32'h4433_2211, 0};
      tbl[2]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0102, 32'h0000_BEEF, 32'h0,         0};
      tbl[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0102, 32'h0,         32'h0000_BEEF, 0};
      tbl[4]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0020, 32'h0000_0080, 32'h0,         0};
      tbl[5]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0020, 32'h0,         32'h0000_0080, 0};
      tbl[6]  = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'hD4C3_B2A1, 32'h0,         0};
      tbl[7]  = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hD4C3_B2A1, 0};
      tbl[8]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 32'h0,         32'h0000_00C3, 0};
      tbl[9]  = '{1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0,         32'h4433_2211, 3};
      tbl[10] = '{1'b0, 1'b0, 2'd1, 32'h0000_1001, 32'h0,         32'h0000_3322, 0};
      tbl[11] = '{1'b0, 1'b1, 2'd1, 32'h0000_0103, 32'hFFFF_1234, 32'h0,         0};
      tbl[12] = '{1'b0, 1'b0, 2'd1, 32'h0000_0103, 32'h0,         32'h0000_1234, 0};

      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {30'd0, if_done, mem_done}, 32'd0);
      chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
      chk("rst_ram_a", ram_a, 32'd0);
      chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
      chk("rst_data", if_data | mem_rdata, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run(tbl[i].is_if, tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].st, 3, got);
         chk($sformatf("tbl%0d_data", i), got, tbl[i].exp);
      end

      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h1000;
      mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h20;
      c = 0;
      while (!mem_done && c < 40) begin
         @(negedge clk);
         c++;
         chk("both_if_wait", {31'd0, if_done}, 32'd0);
      end
      chk("both_mem_cycle", 32'(c), 32'd3);
      chk("both_mem_data", mem_rdata, 32'h80);
      mem_req = 1'b0;
      @(negedge clk);
      c++;
      chk("both_idle_gap", {31'd0, busy}, 32'd0);
      while (!if_done && c < 60) begin
         @(negedge clk);
         c++;
      end
      chk("both_if_cycle", 32'(c), 32'd10);
      chk("both_if_data", if_data, 32'h4433_2211);
      if_req = 1'b0;

      for (int i = 0; i < 16; i++) run(1'b0, 1'b1, 2'd2, 32'h400 + 32'(4 * i), $urandom, 0, 0, got);
      run(1'b0, 1'b1, 2'd2, 32'hFFFF_FFFC, $urandom, 0, 0, got);
      run(1'b0, 1'b1, 2'd2, 32'h0, $urandom, 0, 0, got);
      for (int i = 0; i < 60; i++) begin
         is_if = $urandom_range(0, 3) == 0;
         we = !is_if && $urandom_range(0, 1) == 1;
         sz = 2'($urandom_range(0, 2));
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                         : 32'h400 + 32'($urandom_range(0, 59));
         wd = $urandom;
         n = is_if ? 4 : (sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4);
         st = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
         run(is_if, we, sz, a, wd, st, $urandom_range(1, 3), got);
         if (!we) chk("rand_read", got, ref_read(a, is_if ? 4 : n));
      end

      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h300; mem_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      @(negedge clk);
      chk("rstmid_wr_before", {31'd0, ram_wr}, 32'd1);
      chk("rstmid_a_before", ram_a, 32'h301);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_ram_wr", {31'd0, ram_wr}, 32'd0);
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_done", {30'd0, if_done, mem_done}, 32'd0);
      chk("rstmid_ram_a", ram_a, 32'd0);
      chk("rstmid_ram_dout", {24'd0, ram_dout}, 32'd0);
      chk("rstmid_data", if_data | mem_rdata, 32'd0);
      mem_req = 1'b0;
      rst = 1'b0;
      bad_done = 0;
      repeat (8) begin
         @(negedge clk);
         if (mem_done || if_done || ram_wr) bad_done++;
      end
      chk("rstmid_quiet", 32'(bad_done), 32'd0);
      run(1'b1, 1'b0, 2'd2, 32'h1000, 32'h0, 0, 0, got);
      chk("post_rst_read", got, 32'h4433_2211);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
